sha_host_responder: RTL and testbench
=====================================

Name: sha_host_responder

Overview:
- Memory-side responder and host sequencer for the sha256 hasher.
- Owns a word-addressed RAM and serves the hasher's memory bus (mem_we/mem_addr/mem_write_data/mem_read_data).
- Accepts message words from a host stream, launches the hasher with a start pulse, and captures the 8 digest words the hasher writes back.
- Presents the captured digest and completion/error status to the host.

Parameters:
DEPTH, 1024, RAM size in 32-bit words; addresses wrap modulo DEPTH.
READ_LATENCY, 1, cycles from a mem_addr sample edge to mem_read_data update; range 1..4.
TIMEOUT, 65535, max cycles in WAIT before abort.

Ports:
clk  in  1  clock; also the hasher's mem_clk domain.
reset  in  1  asynchronous, active-high.
cfg_msg_addr  in  16  word base address for message load and hasher message_addr.
cfg_out_addr  in  16  word base address where the hasher writes the digest.
cfg_size  in  32  message length in bytes, passed to the hasher.
in_valid  in  1  host message word valid.
in_ready  out  1  responder accepts a word.
in_data  in  32  message word.
in_last  in  1  final message word.
sha_start  out  1  one-cycle start pulse to the hasher.
sha_message_addr  out  32  zero-extended cfg_msg_addr, latched at START.
sha_size  out  32  cfg_size, latched at START.
sha_output_addr  out  32  zero-extended cfg_out_addr, latched at START.
sha_done  in  1  hasher done.
mem_we  in  1  hasher write enable.
mem_addr  in  16  hasher word address.
mem_write_data  in  32  hasher write data.
mem_read_data  out  32  read data returned to the hasher.
busy  out  1  high in LOAD/START/WAIT.
finished  out  1  one-cycle pulse on completion, success or error.
digest_valid  out  1  captured digest is complete and good.
digest  out  256  word 0 in [255:224] ... word 7 in [31:0].
err  out  1  sticky error; cleared on next accepted first beat.

Behaviour:
- Reset: all outputs 0, state IDLE, capture mask 0, timeout counter 0. RAM contents are not reset.
- A reset mid-operation aborts immediately; no finished pulse.
- States: IDLE, LOAD, START, WAIT, REPORT.
- IDLE:
  - in_ready=1.
  - An accepted beat writes RAM[(cfg_msg_addr+0)%DEPTH], sets idx=1, clears err, digest_valid and the capture mask.
  - Next state is LOAD, or START if in_last is set on that beat.
- LOAD:
  - in_ready=1.
  - Each accepted beat writes RAM[(cfg_msg_addr+idx)%DEPTH] and increments idx (16-bit, wraps).
  - A beat with in_last moves to START.
- START:
  - in_ready=0.
  - sha_start=1 for exactly this cycle.
  - sha_* outputs latched this cycle and held until the next START.
  - Next state WAIT; timeout counter cleared.
- WAIT:
  - in_ready=0.
  - Read path: mem_addr sampled every edge; mem_read_data = RAM[mem_addr%DEPTH] after READ_LATENCY edges (pipelined, one read per cycle).
  - Write path: mem_we=1 writes RAM the same edge. A read of an address written on that same edge returns the old data.
  - Digest capture: a write with (mem_addr - cfg_out_addr) mod 2^16 in 0..7 also stores into the digest word at that offset and sets the mask bit. Rewrites overwrite.
  - sha_done=1 moves to REPORT. If mask==8'hFF, digest_valid=1; otherwise err=1.
  - If the timeout counter reaches TIMEOUT: err=1, go to REPORT.
  - If sha_done and timeout occur in the same cycle, sha_done wins.
- REPORT: finished=1 for one cycle, then IDLE. digest_valid and digest hold until the next first beat.
- Bus outside WAIT: mem_we is ignored (no RAM write) and sets err=1. Reads are still served.
- idx overflow: idx wraps modulo DEPTH, overwriting earlier words. This is not an error.
- sha_done while not in WAIT is ignored.

Test Plan:
1. Load 16 words 0x61626380,0,...,0x18 at cfg_msg_addr=0x0000, cfg_size=3, cfg_out_addr=0x0100 → sha_start pulses once, sha_message_addr=0, sha_output_addr=0x100, sha_size=3.
2. Hasher model reads addrs 0..15 with READ_LATENCY=1, then READ_LATENCY=3 → mem_read_data matches loaded words exactly 1 and 3 edges after each address.
3. Model writes 0xBA7816BF..0xF20015AD to 0x100..0x107, then sha_done → finished pulse, digest_valid=1, digest[255:224]=0xBA7816BF, err=0.
4. Model writes only 0x100..0x106, then sha_done → digest_valid=0, err=1, finished pulse.
5. TIMEOUT=100, no sha_done → err=1 and finished at WAIT cycle 100; return to IDLE; next load clears err.
6. Assert reset during WAIT → all outputs 0 in the same cycle, state IDLE, no finished pulse. A mem_we pulse in IDLE → err=1 and RAM unchanged.

Source files
------------

// File: rtl/sha_host_responder.sv
// sha256 host responder: loads host message words into a local RAM, launches the hasher, captures its digest.
// Latency: mem_read_data follows a sampled mem_addr by READ_LATENCY edges; sha_start one cycle after the last beat.
// Backpressure: in_ready drops from START until REPORT ends; the hasher bus is never stalled.
module sha_host_responder #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  cfg_msg_addr,
  input  logic [15:0]  cfg_out_addr,
  input  logic [31:0]  cfg_size,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         sha_start,
  output logic [31:0]  sha_message_addr,
  output logic [31:0]  sha_size,
  output logic [31:0]  sha_output_addr,
  input  logic         sha_done,
  input  logic         mem_we,
  input  logic [15:0]  mem_addr,
  input  logic [31:0]  mem_write_data,
  output logic [31:0]  mem_read_data,
  output logic         busy,
  output logic         finished,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic         err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   ram [DEPTH];
  logic [31:0]   rd_pipe [READ_LATENCY];
  logic [31:0]   dw [8];
  logic [15:0]   idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    mask;
  logic [7:0]    mask_nxt;

  logic          beat;
  logic          first_beat;
  logic [AW-1:0] host_addr;
  logic [AW-1:0] rd_addr;
  logic          hash_wr;
  logic          bus_err;
  logic [15:0]   dig_off;
  logic          dig_hit;
  logic          done_ev;
  logic          tmo_ev;

  // Word addresses wrap modulo the RAM depth.
  function automatic logic [AW-1:0] wrap_addr(input logic [15:0] a);
    return AW'({16'd0, a} % DEPTH);
  endfunction

  assign beat       = in_valid && in_ready;
  assign first_beat = beat && (state == S_IDLE);
  assign host_addr  = wrap_addr((state == S_IDLE) ? cfg_msg_addr : 16'(cfg_msg_addr + idx));
  assign rd_addr    = wrap_addr(mem_addr);

  // Hasher writes only land in WAIT; anywhere else they are a protocol error.
  assign hash_wr  = mem_we && (state == S_WAIT);
  assign bus_err  = mem_we && (state != S_WAIT);
  assign dig_off  = mem_addr - sha_output_addr[15:0];
  assign dig_hit  = hash_wr && (dig_off < 16'd8);
  assign mask_nxt = dig_hit ? (mask | (8'b1 << dig_off[2:0])) : mask;

  // sha_done has priority over an expiring timeout in the same cycle.
  assign done_ev = (state == S_WAIT) && sha_done;
  assign tmo_ev  = (state == S_WAIT) && !sha_done && (tcnt == TW'(TIMEOUT - 1));

  assign mem_read_data = rd_pipe[READ_LATENCY-1];
  assign digest        = {dw[0], dw[1], dw[2], dw[3], dw[4], dw[5], dw[6], dw[7]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs; in_ready is forced low while reset is held.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    sha_start = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !reset;
        if (in_valid) state_nxt = in_last ? S_START : S_LOAD;
      end
      S_LOAD: begin
        in_ready = !reset;
        busy     = 1'b1;
        if (in_valid && in_last) state_nxt = S_START;
      end
      S_START: begin
        sha_start = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (sha_done || tmo_ev) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        finished  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single RAM write port shared by host loads (IDLE/LOAD) and hasher writes (WAIT).
  always_ff @(posedge clk) begin
    if (beat)         ram[host_addr] <= in_data;
    else if (hash_wr) ram[rd_addr]   <= mem_write_data;
  end

  // Read pipeline: first stage reads old RAM contents, remaining stages add latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= ram[rd_addr];
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Digest capture from hasher writes inside the 8-word output window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) dw[i] <= '0;
    end else if (dig_hit) begin
      dw[dig_off[2:0]] <= mem_write_data;
    end
  end

  // Load index and launch parameters latched on the final beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx              <= '0;
      sha_message_addr <= '0;
      sha_size         <= '0;
      sha_output_addr  <= '0;
    end else if (beat) begin
      idx <= first_beat ? 16'd1 : 16'(idx + 16'd1);
      if (in_last) begin
        sha_message_addr <= {16'd0, cfg_msg_addr};
        sha_size         <= cfg_size;
        sha_output_addr  <= {16'd0, cfg_out_addr};
      end
    end
  end

  // WAIT timeout counter, cleared at launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                tcnt <= '0;
    else if (state == S_START)                tcnt <= '0;
    else if (state == S_WAIT && !done_ev && !tmo_ev) tcnt <= tcnt + TW'(1);
  end

  // Completion status: mask and valid restart on a first beat; err is sticky with set winning over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask         <= '0;
      digest_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      mask <= first_beat ? 8'h00 : mask_nxt;
      if (first_beat)                      digest_valid <= 1'b0;
      else if (done_ev && (&mask_nxt))     digest_valid <= 1'b1;
      err <= (err && !first_beat) || bus_err || (done_ev && !(&mask_nxt)) || tmo_ev;
    end
  end

endmodule

// File: tb/tb_sha_host_responder.sv
// Bench for sha_host_responder: two instances (read latency 1 and 3) on shared stimulus.
// A transaction-level model predicts every output each cycle; literal checks pin the model.
// Randomised loads, bus noise, digest writes, done/timeout endings and a mid-WAIT reset.
module tb_sha_host_responder;

  localparam int D   = 1024;
  localparam int TMO = 100;
  localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_WAIT = 3, P_REPORT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] cfg_msg_addr, cfg_out_addr, mem_addr;
  logic [31:0] cfg_size, in_data, mem_write_data;
  logic in_valid, in_last, sha_done, mem_we;

  logic o1_in_ready, o1_sha_start, o1_busy, o1_finished, o1_digest_valid, o1_err;
  logic [31:0] o1_sha_message_addr, o1_sha_size, o1_sha_output_addr, o1_mem_read_data;
  logic [255:0] o1_digest;
  logic o3_in_ready, o3_sha_start, o3_busy, o3_finished, o3_digest_valid, o3_err;
  logic [31:0] o3_sha_message_addr, o3_sha_size, o3_sha_output_addr, o3_mem_read_data;
  logic [255:0] o3_digest;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int fin_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sha_host_responder #(.DEPTH(D), .READ_LATENCY(1), .TIMEOUT(TMO)) u1 (
    .clk(clk), .reset(reset), .cfg_msg_addr(cfg_msg_addr), .cfg_out_addr(cfg_out_addr),
    .cfg_size(cfg_size), .in_valid(in_valid), .in_ready(o1_in_ready), .in_data(in_data),
    .in_last(in_last), .sha_start(o1_sha_start), .sha_message_addr(o1_sha_message_addr),
    .sha_size(o1_sha_size), .sha_output_addr(o1_sha_output_addr), .sha_done(sha_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(o1_mem_read_data), .busy(o1_busy), .finished(o1_finished),
    .digest_valid(o1_digest_valid), .digest(o1_digest), .err(o1_err));

  sha_host_responder #(.DEPTH(D), .READ_LATENCY(3), .TIMEOUT(TMO)) u3 (
    .clk(clk), .reset(reset), .cfg_msg_addr(cfg_msg_addr), .cfg_out_addr(cfg_out_addr),
    .cfg_size(cfg_size), .in_valid(in_valid), .in_ready(o3_in_ready), .in_data(in_data),
    .in_last(in_last), .sha_start(o3_sha_start), .sha_message_addr(o3_sha_message_addr),
    .sha_size(o3_sha_size), .sha_output_addr(o3_sha_output_addr), .sha_done(sha_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(o3_mem_read_data), .busy(o3_busy), .finished(o3_finished),
    .digest_valid(o3_digest_valid), .digest(o3_digest), .err(o3_err));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]  m_ram [D];
  bit           m_known [D];
  int           ph;
  int           wcyc;
  logic [15:0]  m_idx;
  logic         m_err, m_dv, bus_e;
  logic [7:0]   m_mask;
  logic [255:0] m_dig;
  logic [31:0]  m_ma, m_sz, m_oa;
  logic [32:0]  hist [4];    // {known, data} of reads, newest first
  int           ra, ha;
  logic [15:0]  off;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = P_IDLE; wcyc = 0; m_idx = 0; m_err = 0; m_dv = 0; m_mask = 0; m_dig = '0;
      m_ma = 0; m_sz = 0; m_oa = 0;
      for (int i = 0; i < 4; i++) hist[i] = {1'b1, 32'd0};
    end else begin
      bus_e = 0;
      ra = int'(mem_addr) % D;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {m_known[ra], m_ram[ra]};
      if (mem_we) begin
        if (ph == P_WAIT) begin
          m_ram[ra] = mem_write_data; m_known[ra] = 1;
          off = mem_addr - m_oa[15:0];
          if (off < 8) begin
            m_dig[255 - 32*int'(off) -: 32] = mem_write_data;
            m_mask[off[2:0]] = 1'b1;
          end
        end else bus_e = 1;
      end
      case (ph)
        P_IDLE, P_LOAD: if (in_valid) begin
          ha = int'(16'(cfg_msg_addr + ((ph == P_IDLE) ? 16'd0 : m_idx))) % D;
          m_ram[ha] = in_data; m_known[ha] = 1;
          if (ph == P_IDLE) begin m_idx = 1; m_err = 0; m_dv = 0; m_mask = 0; end
          else m_idx = m_idx + 16'd1;
          if (in_last) begin
            ph = P_START; m_ma = {16'd0, cfg_msg_addr}; m_sz = cfg_size; m_oa = {16'd0, cfg_out_addr};
          end else ph = P_LOAD;
        end
        P_START: begin ph = P_WAIT; wcyc = 0; end
        P_WAIT: begin
          wcyc++;
          if (sha_done) begin
            ph = P_REPORT;
            if (m_mask == 8'hFF) m_dv = 1; else m_err = 1;
          end else if (wcyc == TMO) begin
            ph = P_REPORT; m_err = 1;
          end
        end
        P_REPORT: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
      if (bus_e) m_err = 1;
    end
  end

  task automatic cmp(input string t, input logic rdy, input logic st, input logic [31:0] ma,
                     input logic [31:0] sz, input logic [31:0] oa, input logic [31:0] rd,
                     input logic bs, input logic fn, input logic dv, input logic [255:0] dg,
                     input logic er, input logic [32:0] h);
    chk({t, "in_ready"}, rdy, (ph == P_IDLE || ph == P_LOAD));
    chk({t, "sha_start"}, st, ph == P_START);
    chk({t, "busy"}, bs, (ph == P_LOAD || ph == P_START || ph == P_WAIT));
    chk({t, "finished"}, fn, ph == P_REPORT);
    chk({t, "msg_addr"}, ma, m_ma);
    chk({t, "size"}, sz, m_sz);
    chk({t, "out_addr"}, oa, m_oa);
    chk({t, "digest_valid"}, dv, m_dv);
    chk({t, "digest"}, dg, m_dig);
    chk({t, "err"}, er, m_err);
    if (h[32]) chk({t, "read_data"}, rd, h[31:0]);
  endtask

  // Compare both instances against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      cmp("l1_", o1_in_ready, o1_sha_start, o1_sha_message_addr, o1_sha_size, o1_sha_output_addr,
          o1_mem_read_data, o1_busy, o1_finished, o1_digest_valid, o1_digest, o1_err, hist[0]);
      cmp("l3_", o3_in_ready, o3_sha_start, o3_sha_message_addr, o3_sha_size, o3_sha_output_addr,
          o3_mem_read_data, o3_busy, o3_finished, o3_digest_valid, o3_digest, o3_err, hist[2]);
      if (o1_sha_start) start_cnt++;
      if (o1_finished) fin_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] msg [1030];
  logic [31:0] abc [8];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    int g;
    in_valid = 1; in_data = d; in_last = last; g = 0;
    while (!o1_in_ready && g < 20) begin tick(); g++; end
    if (!o1_in_ready) chk("in_ready_bound", o1_in_ready, 1);
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic load(input int n, input bit gaps, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        mem_addr = 16'($urandom);
        mem_we = noise && ($urandom_range(0, 4) == 0);
        mem_write_data = $urandom;
        tick();
        mem_we = 0;
      end
      beat(msg[i], i == n - 1);
    end
  endtask

  task automatic wait_fin();
    int c;
    c = 0;
    while (!o1_finished && c < 300) begin tick(); c++; end
    chk("finish_bound", o1_finished, 1);
  endtask

  task automatic finish_done();
    sha_done = 1; tick(); sha_done = 0;
    wait_fin();
  endtask

  initial begin
    int s0, f0, st;
    abc[0] = 32'hBA7816BF; abc[1] = 32'h8F01CFEA; abc[2] = 32'h414140DE; abc[3] = 32'h5DAE2223;
    abc[4] = 32'hB00361A3; abc[5] = 32'h96177A9C; abc[6] = 32'hB410FF61; abc[7] = 32'hF20015AD;
    in_valid = 0; in_data = 0; in_last = 0; cfg_msg_addr = 0; cfg_out_addr = 0; cfg_size = 0;
    sha_done = 0; mem_we = 0; mem_addr = 0; mem_write_data = 0;
    #1 reset = 1;
    #2;
    chk("rst_in_ready", o1_in_ready, 0);
    chk("rst_busy", o1_busy, 0);
    chk("rst_rdata", o3_mem_read_data, 0);
    tick(); tick();
    reset = 0;
    tick();

    // Test 1: "abc" padded block at address 0.
    cfg_msg_addr = 16'h0000; cfg_size = 32'd3; cfg_out_addr = 16'h0100;
    msg[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) msg[i] = 32'h0;
    msg[15] = 32'h00000018;
    s0 = start_cnt;
    load(16, 1, 0);
    chk("t1_start", o1_sha_start, 1);
    chk("t1_msg_addr", o1_sha_message_addr, 32'h0);
    chk("t1_out_addr", o1_sha_output_addr, 32'h100);
    chk("t1_size", o1_sha_size, 32'd3);
    tick();
    // Test 2: pipelined reads of the loaded block.
    for (int i = 0; i < 18; i++) begin
      mem_addr = (i < 16) ? 16'(i) : 16'd0;
      tick();
      if (i < 16) chk("t2_rl1", o1_mem_read_data, msg[i]);
      if (i >= 2) chk("t2_rl3", o3_mem_read_data, msg[i-2]);
    end
    // Test 3: full digest written back.
    for (int k = 0; k < 8; k++) begin
      mem_we = 1; mem_addr = 16'(16'h100 + k); mem_write_data = abc[k]; tick();
    end
    mem_we = 0;
    finish_done();
    chk("t3_dv", o1_digest_valid, 1);
    chk("t3_word0", o1_digest[255:224], 32'hBA7816BF);
    chk("t3_word7", o1_digest[31:0], 32'hF20015AD);
    chk("t3_err", o1_err, 0);
    chk("t3_one_start", start_cnt - s0, 1);
    tick();

    // Bus write in IDLE flags err and leaves RAM untouched.
    mem_we = 1; mem_addr = 16'd15; mem_write_data = 32'hDEADBEEF; tick();
    mem_we = 0;
    chk("idle_we_err", o1_err, 1);
    tick();
    chk("idle_we_ram", o1_mem_read_data, 32'h18);

    // Test 4: digest missing its last word.
    cfg_msg_addr = 16'h0040;
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    load(16, 1, 0);
    tick();
    for (int k = 0; k < 7; k++) begin
      mem_we = 1; mem_addr = 16'(16'h100 + k); mem_write_data = $urandom; tick();
    end
    mem_we = 0;
    finish_done();
    chk("t4_dv", o1_digest_valid, 0);
    chk("t4_err", o1_err, 1);
    tick();

    // Test 5: timeout with no sha_done.
    cfg_msg_addr = 16'h0080;
    for (int i = 0; i < 4; i++) msg[i] = $urandom;
    load(4, 0, 0);
    st = cyc;
    wait_fin();
    chk("t5_tmo_cycles", cyc - st, 101);
    chk("t5_err", o1_err, 1);
    tick();
    chk("t5_idle", o1_in_ready, 1);
    beat(32'h1234, 0);
    chk("t5_err_clear", o1_err, 0);
    beat(32'h5678, 1);
    tick();
    finish_done();
    tick();

    // idx wrap over the whole RAM.
    cfg_msg_addr = 16'h03F8;
    for (int i = 0; i < 1030; i++) msg[i] = $urandom;
    load(1030, 0, 0);
    tick();
    mem_addr = 16'h03F8; tick();
    chk("wrap_first", o1_mem_read_data, msg[1024]);
    mem_addr = 16'h03FE; tick();
    chk("wrap_kept", o1_mem_read_data, msg[6]);
    mem_addr = 16'h03FD; tick();
    chk("wrap_last", o1_mem_read_data, msg[1029]);
    finish_done();
    tick();

    // Randomised transactions.
    for (int t = 0; t < 10; t++) begin
      int n, mode, ops;
      cfg_msg_addr = 16'($urandom); cfg_out_addr = 16'($urandom); cfg_size = $urandom;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) msg[i] = $urandom;
      load(n, 1, 1);
      tick();
      mode = $urandom_range(0, 2);
      ops = $urandom_range(0, 30);
      for (int k = 0; k < ops; k++) begin
        case ($urandom_range(0, 2))
          0: mem_addr = 16'($urandom);
          1: mem_addr = 16'(cfg_out_addr + $urandom_range(0, 9));
          default: mem_addr = 16'(cfg_msg_addr + $urandom_range(0, 24));
        endcase
        mem_we = ($urandom_range(0, 9) < 3);
        mem_write_data = $urandom;
        tick();
      end
      mem_we = 0;
      if (mode == 0) begin
        for (int k = 0; k < 8; k++) begin
          mem_we = 1; mem_addr = 16'(cfg_out_addr + k); mem_write_data = $urandom; tick();
        end
        mem_we = 0;
      end
      if (mode == 2) wait_fin();
      else finish_done();
      tick();
    end

    // Test 6: reset in the middle of WAIT.
    cfg_msg_addr = 16'h0020; cfg_out_addr = 16'h0100;
    for (int i = 0; i < 5; i++) msg[i] = $urandom;
    load(5, 0, 0);
    tick(); tick(); tick();
    f0 = fin_cnt;
    #2 reset = 1;
    #1;
    chk("t6_busy", o1_busy, 0);
    chk("t6_ready", o1_in_ready, 0);
    chk("t6_msg_addr", o1_sha_message_addr, 0);
    chk("t6_fin", o3_finished, 0);
    chk("t6_rdata", o3_mem_read_data, 0);
    tick();
    reset = 0;
    repeat (5) tick();
    chk("t6_no_finish", fin_cnt - f0, 0);
    chk("t6_idle", o1_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
